// File: rtl/dmem_requester_if.sv
// Bundle of the pipeline request/response handshake and the data-RAM bus.
// master: the requester; slave: the pipeline plus RAM environment that drives it.
interface dmem_requester_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        resp_oor;
   logic        stall;

   logic        cs;
   logic        we;
   logic [31:0] addr;
   logic [31:0] din;
   logic        ack;
   logic [31:0] dout;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, ack, dout,
      output req_ready, resp_valid, resp_rdata, resp_err, resp_oor, stall,
             cs, we, addr, din
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, ack, dout,
      input  req_ready, resp_valid, resp_rdata, resp_err, resp_oor, stall,
             cs, we, addr, din
   );
endinterface

// File: rtl/dmem_requester.sv
// Pipeline-side initiator for the multi-cycle data RAM: one access per handshake, registered
// outputs. Define DMEM_REQ_WATCHDOG_EN to build the WAIT-state abort watchdog.
module dmem_requester #(
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic              clk,
   input logic              rst,
   dmem_requester_if.master bus
);

   if (ADDR_WIDTH < 1 || ADDR_WIDTH > 31) begin : g_bad_addr_width
      $error("dmem_requester: ADDR_WIDTH must be 1..31");
   end
   if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("dmem_requester: TIMEOUT_CYCLES must be 4..255");
   end

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] din_q, din_d;
   logic        we_q, we_d;
   logic        cs_q, cs_d;
   logic        oor_q, oor_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic        resp_oor_q, resp_oor_d;
   logic        req_oor;
   logic        expire;

   assign req_oor = (bus.req_addr >> ADDR_WIDTH) != 32'd0;

`ifdef DMEM_REQ_WATCHDOG_EN
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;

   // Cleared while idle so every WAIT starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle) begin
         cnt_d = '0;
      end else if (state_q == StWait) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (state_q == StWait) && (cnt_q == TimeoutLast);
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      din_d        = din_q;
      we_d         = we_q;
      cs_d         = cs_q;
      oor_d        = oor_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = 1'b0;
      resp_oor_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               din_d   = bus.req_wdata;
               we_d    = bus.req_we;
               oor_d   = req_oor;
               cs_d    = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            // RAM bus holds its value here; ack takes priority over an expiring watchdog.
            if (bus.ack) begin
               resp_rdata_d = we_q ? 32'd0 : bus.dout;
               resp_valid_d = 1'b1;
               resp_oor_d   = oor_q;
               cs_d         = 1'b0;
               we_d         = 1'b0;
               state_d      = StResp;
            end else if (expire) begin
               resp_rdata_d = 32'd0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_oor_d   = oor_q;
               cs_d         = 1'b0;
               we_d         = 1'b0;
               state_d      = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cs_d    = 1'b0;
            we_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         din_q        <= '0;
         we_q         <= 1'b0;
         cs_q         <= 1'b0;
         oor_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         resp_oor_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         we_q         <= we_d;
         cs_q         <= cs_d;
         oor_q        <= oor_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         resp_oor_q   <= resp_oor_d;
      end
   end

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_oor   = resp_oor_q;
   assign bus.stall      = cs_q;
   assign bus.cs         = cs_q;
   assign bus.we         = we_q;
   assign bus.addr       = addr_q;
   assign bus.din        = din_q;

endmodule

// File: tb/tb_dmem_requester.sv
// Directed bench for dmem_requester with a small latency-programmable RAM model.
// Watchdog scenarios run only when DMEM_REQ_WATCHDOG_EN is defined.
module tb_dmem_requester;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_requester_if bus ();

   dmem_requester #(
      .ADDR_WIDTH     (5),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM model: acks ram_lat negedges after cs is first seen high, returns 0 out of range.
   int unsigned ram_lat    = 3;
   logic        ram_ack_en = 1'b1;
   logic        ram_ack    = 1'b0;
   logic        stray_ack  = 1'b0;
   logic [31:0] ram_dout   = '0;
   int unsigned ram_cnt    = 0;
   logic [31:0] mem [32];

   assign bus.ack  = ram_ack | stray_ack;
   assign bus.dout = ram_dout;

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | i;
         mem[5]  <= 32'hDEAD_BEEF;
         ram_ack <= 1'b0;
         ram_cnt <= 0;
      end else if (!bus.cs || ram_ack) begin
         ram_ack <= 1'b0;
         ram_cnt <= 0;
      end else if (ram_cnt == ram_lat) begin
         if (ram_ack_en) begin
            ram_ack <= 1'b1;
            if (bus.we) begin
               ram_dout <= 32'hBAD0_BAD0;
               if ((bus.addr >> 5) == 32'd0) mem[bus.addr[4:0]] <= bus.din;
            end else begin
               ram_dout <= ((bus.addr >> 5) != 32'd0) ? 32'd0 : mem[bus.addr[4:0]];
            end
         end
      end else begin
         ram_cnt <= ram_cnt + 1;
      end
   end

   // One access from idle; req_addr switches to alt after acceptance.
   task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] alt, output logic [31:0] rd, output logic er,
                             output logic oo, output int stalls, output int viol);
      logic got;
      got    = 1'b0;
      stalls = 0;
      viol   = 0;
      rd     = 'x;
      er     = 1'bx;
      oo     = 1'bx;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_we    = w;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = alt;
      bus.req_wdata = ~wd;
      for (int i = 0; i < 64 && !got; i++) begin
         if (bus.we && !bus.cs) viol++;
         if (bus.resp_valid) begin
            got = 1'b1;
            rd  = bus.resp_rdata;
            er  = bus.resp_err;
            oo  = bus.resp_oor;
            if (bus.cs || bus.stall || bus.req_ready) viol++;
         end else begin
            if (bus.stall) begin
               stalls++;
               if (bus.addr !== a || bus.din !== wd || bus.we !== w || bus.req_ready) viol++;
               if (bus.resp_err || bus.resp_oor) viol++;
            end
            @(posedge clk); #1;
         end
      end
      check_eq("resp_seen", {31'd0, got}, 32'd1);
      if (got) begin
         @(posedge clk); #1;
         if (bus.resp_valid || !bus.req_ready || bus.resp_err || bus.resp_oor || bus.cs) viol++;
      end
   endtask

   logic [31:0] rd;
   logic        er, oo;
   int          st, vi, pulses;

   initial begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      #1;
      check_eq("rst_cs", {31'd0, bus.cs}, 32'd0);
      check_eq("rst_we", {31'd0, bus.we}, 32'd0);
      check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
      check_eq("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check_eq("rst_flags", {30'd0, bus.resp_err, bus.resp_oor}, 32'd0);
      check_eq("rst_addr", bus.addr, 32'd0);
      check_eq("rst_din", bus.din, 32'd0);
      check_eq("rst_rdata", bus.resp_rdata, 32'd0);
      check_eq("rst_ready", {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      ram_lat = 3;
      run_access(1'b0, 32'd5, 32'd0, 32'd5, rd, er, oo, st, vi);
      check_eq("load5_rdata", rd, 32'hDEAD_BEEF);
      check_eq("load5_err", {31'd0, er}, 32'd0);
      check_eq("load5_oor", {31'd0, oo}, 32'd0);
      check_eq("load5_stall", st, 32'd4);
      check_eq("load5_viol", vi, 32'd0);

      ram_lat = 2;
      run_access(1'b1, 32'd7, 32'h1234_5678, 32'd7, rd, er, oo, st, vi);
      check_eq("store7_rdata", rd, 32'd0);
      check_eq("store7_stall", st, 32'd3);
      check_eq("store7_viol", vi, 32'd0);

      ram_lat = 0;
      run_access(1'b0, 32'd7, 32'hFFFF_0000, 32'd7, rd, er, oo, st, vi);
      check_eq("load7_rdata", rd, 32'h1234_5678);
      check_eq("load7_stall", st, 32'd1);
      check_eq("load7_viol", vi, 32'd0);

      ram_lat = 3;
      run_access(1'b0, 32'd3, 32'd0, 32'd9, rd, er, oo, st, vi);
      check_eq("hold_rdata", rd, 32'hA5A5_0003);
      check_eq("hold_stall", st, 32'd4);
      check_eq("hold_viol", vi, 32'd0);

      ram_lat = 1;
      run_access(1'b0, 32'h40, 32'd0, 32'h40, rd, er, oo, st, vi);
      check_eq("oor_flag", {31'd0, oo}, 32'd1);
      check_eq("oor_rdata", rd, 32'd0);
      check_eq("oor_err", {31'd0, er}, 32'd0);
      check_eq("oor_stall", st, 32'd2);
      check_eq("oor_viol", vi, 32'd0);

      // Stray ack while idle must be ignored.
      @(posedge clk); #1;
      stray_ack = 1'b1;
      @(posedge clk); #1;
      stray_ack = 1'b0;
      check_eq("stray_ready", {31'd0, bus.req_ready}, 32'd1);
      check_eq("stray_cs", {31'd0, bus.cs}, 32'd0);
      @(posedge clk); #1;
      check_eq("stray_resp", {31'd0, bus.resp_valid}, 32'd0);

      // Reset pulled mid-WAIT drops the access without a response.
      ram_lat = 3;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'd5;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("pre_rst_cs", {31'd0, bus.cs}, 32'd1);
      rst = 1'b0;
      #1;
      check_eq("midrst_cs", {31'd0, bus.cs}, 32'd0);
      check_eq("midrst_stall", {31'd0, bus.stall}, 32'd0);
      check_eq("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
      check_eq("midrst_addr", bus.addr, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.resp_valid || bus.cs) pulses++;
         @(posedge clk); #1;
      end
      check_eq("midrst_noresp", pulses, 32'd0);
      run_access(1'b0, 32'd5, 32'd0, 32'd5, rd, er, oo, st, vi);
      check_eq("postrst_rdata", rd, 32'hDEAD_BEEF);
      check_eq("postrst_stall", st, 32'd4);
      check_eq("postrst_viol", vi, 32'd0);

`ifdef DMEM_REQ_WATCHDOG_EN
      ram_ack_en = 1'b0;
      run_access(1'b0, 32'd5, 32'd0, 32'd5, rd, er, oo, st, vi);
      check_eq("wdog_err", {31'd0, er}, 32'd1);
      check_eq("wdog_rdata", rd, 32'd0);
      check_eq("wdog_stall", st, 32'd8);
      check_eq("wdog_viol", vi, 32'd0);
      ram_ack_en = 1'b1;
      ram_lat    = 7;
      run_access(1'b0, 32'd5, 32'd0, 32'd5, rd, er, oo, st, vi);
      check_eq("wdog_tie_err", {31'd0, er}, 32'd0);
      check_eq("wdog_tie_rdata", rd, 32'hDEAD_BEEF);
      check_eq("wdog_tie_stall", st, 32'd8);
`endif

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule
